// File: rtl/cam_emul.sv
// OV7670-style camera transmitter: streams RGB444 pixels from frame RAM as vsync/href/byte traffic.
// All outputs are registered one cycle behind the frame-position FSM and counters.
module cam_emul #(
    parameter int AW        = 15,
    parameter int DW        = 12,
    parameter int H_ACT     = 160,
    parameter int V_ACT     = 120,
    parameter int H_BLANK   = 16,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 2,
    parameter int VFP_LINES = 2
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          enable,
    output logic [AW-1:0] DP_RAM_addr_out,
    input  logic [DW-1:0] DP_RAM_data_out,
    output logic          CAM_vsync,
    output logic          CAM_href,
    output logic [7:0]    CAM_px_data,
    output logic          frame_done
);
    localparam int LINE = 2*H_ACT + H_BLANK;
    localparam int CW   = $clog2(LINE);
    localparam int LW   = $clog2(V_ACT + VS_LINES + VBP_LINES + VFP_LINES + 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] col;
    logic [LW-1:0] line, n_lines;
    logic [7:0]    pix;
    logic          last_col, end_of_state;
    logic          vsync_d, href_d, done_d;
    logic [7:0]    data_d;

    always_comb begin
        n_lines = LW'(1);
        case (state)
            VSYNC:   n_lines = LW'(VS_LINES);
            VBP:     n_lines = LW'(VBP_LINES);
            ACTIVE:  n_lines = LW'(V_ACT);
            VFP:     n_lines = LW'(VFP_LINES);
            default: n_lines = LW'(1);
        endcase
    end

    assign last_col     = (col == CW'(LINE-1));
    assign end_of_state = last_col && (line == n_lines - LW'(1));

    always_ff @(posedge CAM_pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // enable only matters in IDLE and at VFP exit, so a frame in flight always completes
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable)       state_n = VSYNC;
            VSYNC:   if (end_of_state) state_n = VBP;
            VBP:     if (end_of_state) state_n = ACTIVE;
            ACTIVE:  if (end_of_state) state_n = VFP;
            VFP:     if (end_of_state) state_n = enable ? VSYNC : IDLE;
            default:                   state_n = IDLE;
        endcase
    end

    always_comb begin
        vsync_d = (state == VSYNC);
        href_d  = (state == ACTIVE) && (col < CW'(2*H_ACT));
        done_d  = (state == VFP) && (col == '0) && (line == '0);
        data_d  = '0;
        if (href_d)
            data_d = col[0] ? pix : {4'h0, DP_RAM_data_out[DW-1 -: 4]};
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst || state == IDLE) begin
            col  <= '0;
            line <= '0;
        end else if (last_col) begin
            col  <= '0;
            line <= end_of_state ? '0 : line + LW'(1);
        end else begin
            col  <= col + CW'(1);
        end
    end

    // Even byte consumes the RAM word and bumps the address, so the next pixel's
    // word is already on the data bus by the following even column.
    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            DP_RAM_addr_out <= '0;
            pix             <= '0;
            CAM_vsync       <= 1'b0;
            CAM_href        <= 1'b0;
            CAM_px_data     <= '0;
            frame_done      <= 1'b0;
        end else begin
            if (state != ACTIVE)
                DP_RAM_addr_out <= '0;
            else if (href_d && !col[0])
                DP_RAM_addr_out <= DP_RAM_addr_out + AW'(1);
            if (href_d && !col[0])
                pix <= DP_RAM_data_out[7:0];
            CAM_vsync   <= vsync_d;
            CAM_href    <= href_d;
            CAM_px_data <= data_d;
            frame_done  <= done_d;
        end
    end
endmodule
